// File: rtl/instruction_fetch_if.sv
// Instruction-memory read bus between the fetch stage and the instruction memory.
// The read is asynchronous: imem_instr answers imem_addr in the same cycle.
interface instruction_fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;

  modport master (output imem_addr, input imem_instr);
  modport slave  (input imem_addr, output imem_instr);
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads the instruction memory and loads the IF/ID register.
// It also resolves J-type jumps inside the stage, so they need no redirect from later stages.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] IMEM_WORDS = 32'd32,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_target,
  instruction_fetch_if.master        imem,
  output logic [31:0]                ifid_instr,
  output logic [31:0]                ifid_pc_plus4,
  output logic                       ifid_valid,
  output logic                       addr_fault,
  output logic [31:0]                fetch_count
);

  localparam logic [5:0] OP_J = 6'b000010;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  logic        fault_q, fault_d;
  logic [31:0] count_q, count_d;

  logic [31:0] pc_plus4;
  logic        in_range;
  logic [31:0] fw;
  logic        is_j;
  logic [31:0] j_target;
  logic [31:0] redir_pc;
  logic        squash;

  assign imem.imem_addr = pc_q;

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    in_range = ({2'b00, pc_q[31:2]} < IMEM_WORDS);
    // Out-of-range reads never reach decode; a bubble takes their place.
    fw       = in_range ? imem.imem_instr : NOP_WORD;
    is_j     = in_range && (fw[31:26] == OP_J);
    j_target = {pc_plus4[31:28], fw[25:0], 2'b00};
    redir_pc = {redirect_target[31:2], 2'b00};
    squash   = flush | redirect_valid;
  end

  always_comb begin
    if (redirect_valid)  pc_d = redir_pc;
    else if (stall)      pc_d = pc_q;
    else if (is_j)       pc_d = j_target;
    else                 pc_d = pc_plus4;
  end

  // A squash beats the stall: the held word is already stale once the path changes.
  always_comb begin
    ifid_d  = ifid_q;
    fault_d = fault_q;
    count_d = count_q;
    if (squash) begin
      ifid_d.instr = NOP_WORD;
      ifid_d.valid = 1'b0;
      fault_d      = 1'b0;
    end else if (!stall) begin
      ifid_d.instr    = fw;
      ifid_d.pc_plus4 = pc_plus4;
      ifid_d.valid    = in_range;
      fault_d         = !in_range;
      if (in_range) count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q            <= RESET_PC;
      ifid_q.instr    <= NOP_WORD;
      ifid_q.pc_plus4 <= 32'd0;
      ifid_q.valid    <= 1'b0;
      fault_q         <= 1'b0;
      count_q         <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  assign ifid_instr    = ifid_q.instr;
  assign ifid_pc_plus4 = ifid_q.pc_plus4;
  assign ifid_valid    = ifid_q.valid;
  assign addr_fault    = fault_q;
  assign fetch_count   = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios with literal expectations, then random
// stall/flush/redirect/reset traffic compared every cycle against a reference model.
module tb_instruction_fetch;

  localparam int IMEM_WORDS = 32;

  logic        clk = 1'b0;
  logic        reset, stall, flush, redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] ifid_instr, ifid_pc_plus4, fetch_count;
  logic        ifid_valid, addr_fault;

  logic [31:0] mem [0:255];

  instruction_fetch_if imem_bus();
  assign imem_bus.imem_instr = mem[imem_bus.imem_addr[9:2]];

  instruction_fetch #(
    .RESET_PC(32'h0), .IMEM_WORDS(32'd32), .NOP_WORD(32'h0)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem(imem_bus),
    .ifid_instr(ifid_instr), .ifid_pc_plus4(ifid_pc_plus4), .ifid_valid(ifid_valid),
    .addr_fault(addr_fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference state, advanced once per rising edge from the rules of the stage.
  logic [31:0] m_pc, m_instr, m_pp4, m_cnt;
  logic        m_valid, m_fault;
  bit          model_ok = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [31:0] pc4, word, nxt;
    bit          ok;
    if (reset) begin
      m_pc = 0; m_instr = 0; m_pp4 = 0; m_valid = 0; m_fault = 0; m_cnt = 0;
      model_ok = 1;
      return;
    end
    pc4  = m_pc + 4;
    ok   = (m_pc / 4) < IMEM_WORDS;
    word = ok ? mem[m_pc[9:2]] : 32'h0;
    if (redirect_valid)                    nxt = redirect_target & ~32'd3;
    else if (stall)                        nxt = m_pc;
    else if (ok && word[31:26] == 6'd2)    nxt = {pc4[31:28], word[25:0], 2'b00};
    else                                   nxt = pc4;
    if (flush || redirect_valid) begin
      m_instr = 0; m_valid = 0; m_fault = 0;
    end else if (!stall) begin
      m_instr = word; m_pp4 = pc4; m_valid = ok; m_fault = !ok;
      if (ok) m_cnt = m_cnt + 1;
    end
    m_pc = nxt;
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      chk("imem_addr",     imem_bus.imem_addr, m_pc);
      chk("ifid_instr",    ifid_instr,    m_instr);
      chk("ifid_pc_plus4", ifid_pc_plus4, m_pp4);
      chk("ifid_valid",    {31'd0, ifid_valid}, {31'd0, m_valid});
      chk("addr_fault",    {31'd0, addr_fault}, {31'd0, m_fault});
      chk("fetch_count",   fetch_count,   m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic f,
                       input logic rv, input logic [31:0] tgt);
    reset = r; stall = s; flush = f; redirect_valid = rv; redirect_target = tgt;
    tick();
  endtask

  function automatic logic [31:0] non_j(input logic [31:0] w);
    logic [31:0] v;
    v = w;
    if (v[31:26] == 6'd2) v[31:26] = 6'h23;
    return v;
  endfunction

  initial begin
    reset = 1; stall = 0; flush = 0; redirect_valid = 0; redirect_target = 0;
    for (int i = 0; i < 256; i++) mem[i] = (i < IMEM_WORDS) ? non_j($urandom) : $urandom;
    mem[0]  = 32'h012A_4024;  // and
    mem[1]  = 32'h012A_4025;  // or
    mem[2]  = 32'h012A_4027;  // nor
    mem[3]  = 32'h012A_4028;  // nand
    mem[10] = 32'h0800_0005;  // j 5
    mem[33] = 32'h0800_0001;  // out-of-range J must not be taken

    // Reset state and four free-running fetches
    drive(1, 0, 0, 0, 0);
    chk("rst_pc", imem_bus.imem_addr, 32'd0);
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      drive(0, 0, 0, 0, 0);
      chk("free_pc", imem_bus.imem_addr, 32'(4 * k));
      chk("free_pp4", ifid_pc_plus4, 32'(4 * k));
    end
    chk("free_instr3", ifid_instr, 32'h012A_4028);
    chk("free_count", fetch_count, 32'd4);

    // Stall at pc=8
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    chk("stall_pc", imem_bus.imem_addr, 32'd8);
    chk("stall_instr", ifid_instr, 32'h012A_4025);
    chk("stall_pp4", ifid_pc_plus4, 32'd8);
    chk("stall_count", fetch_count, 32'd2);
    drive(0, 0, 0, 0, 0);
    chk("release_instr", ifid_instr, 32'h012A_4027);
    chk("release_count", fetch_count, 32'd3);

    // Early J at pc=40
    drive(0, 0, 0, 1, 32'd40);
    drive(0, 0, 0, 0, 0);
    chk("j_pc", imem_bus.imem_addr, 32'd20);
    chk("j_instr", ifid_instr, 32'h0800_0005);
    drive(0, 0, 0, 0, 0);
    chk("j_tgt_instr", ifid_instr, mem[5]);
    chk("j_tgt_pp4", ifid_pc_plus4, 32'd24);
    chk("j_count", fetch_count, 32'd5);

    // Redirect with unaligned target beats a simultaneous stall
    drive(0, 0, 0, 1, 32'd84);
    drive(0, 1, 0, 1, 32'h0000_0003);
    chk("redir_pc", imem_bus.imem_addr, 32'd0);
    chk("redir_valid", {31'd0, ifid_valid}, 32'd0);
    chk("redir_instr", ifid_instr, 32'd0);

    // Run off the end of memory
    drive(0, 0, 0, 1, 32'd124);
    drive(0, 0, 0, 0, 0);
    chk("edge_valid", {31'd0, ifid_valid}, 32'd1);
    chk("edge_fault", {31'd0, addr_fault}, 32'd0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("oor_pc", imem_bus.imem_addr, 32'd136);
    chk("oor_fault", {31'd0, addr_fault}, 32'd1);
    chk("oor_valid", {31'd0, ifid_valid}, 32'd0);
    chk("oor_instr", ifid_instr, 32'd0);
    chk("oor_count", fetch_count, 32'd6);
    drive(0, 0, 0, 1, 32'd0);
    chk("oor_clear", {31'd0, addr_fault}, 32'd0);

    // Reset while stalled, then PC wrap
    drive(0, 0, 0, 1, 32'd12);
    drive(1, 1, 0, 0, 0);
    chk("rst_stall_pc", imem_bus.imem_addr, 32'd0);
    chk("rst_stall_count", fetch_count, 32'd0);
    chk("rst_stall_pp4", ifid_pc_plus4, 32'd0);
    drive(0, 0, 0, 1, 32'hFFFF_FFFC);
    chk("top_pc", imem_bus.imem_addr, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0, 0);
    chk("wrap_pc", imem_bus.imem_addr, 32'd0);
    chk("wrap_pp4", ifid_pc_plus4, 32'd0);
    chk("wrap_fault", {31'd0, addr_fault}, 32'd1);

    // Random traffic, in-range memory seeded with jumps
    for (int i = 0; i < IMEM_WORDS; i++)
      mem[i] = ($urandom_range(0, 4) == 0) ? {6'b000010, 26'($urandom_range(0, 40))}
                                           : non_j($urandom);
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC
                                         : 32'($urandom_range(0, 47) * 4 + $urandom_range(0, 3));
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0, tgt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
